full_adder_delay_reg: RTL and testbench
=======================================

Name: full_adder_delay_reg

Overview:
- 1-bit full adder that models gate propagation delay as clock-cycle latency.
- Outputs sum, carry-out, propagate and generate, each through its own configurable-depth register pipeline with a matching valid flag.
- Leaf cell for ripple, carry-skip, carry-select and CLA adder chains.
- Lets cycle-accurate benches compare carry-path and skip-path timing.

Parameters:
- SUM_LAT, 2, cycles from accepted input to sum/sum_valid (two XOR levels); legal range 1..16.
- COUT_LAT, 2, cycles from accepted input to cout/cout_valid (AND-OR path); legal range 1..16.
- PG_LAT, 1, cycles from accepted input to p/g/pg_valid (single gate level); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a/b/cin sampled on this cycle's rising edge when high
- a  input  1  addend bit
- b  input  1  addend bit
- cin  input  1  carry in
- sum  output  1  a^b^cin, SUM_LAT cycles after sampling
- sum_valid  output  1  marks sum as valid
- cout  output  1  (a&b)|(a&cin)|(b&cin), COUT_LAT cycles after sampling
- cout_valid  output  1  marks cout as valid
- p  output  1  propagate a^b, PG_LAT cycles after sampling
- g  output  1  generate a&b, PG_LAT cycles after sampling
- pg_valid  output  1  marks p/g as valid

Behaviour:
- Reset:
  - rst high clears every pipeline stage, data and valid, immediately without waiting for clk.
  - While rst is high, all outputs are 0.
  - In-flight samples are discarded and never emerge after reset.
- First edge after release: the first rising edge with rst low samples inputs normally.
- Combinational results:
  - Computed from a, b, cin in the sampling cycle.
  - Each result is loaded into stage 1 of its own pipeline together with in_valid.
  - Each pipeline is a shift register of depth equal to its latency parameter.
  - Stages shift every clock unconditionally: no stall and no backpressure.
- Latency, with a sample at edge k:
  - sum and sum_valid update at edge k+SUM_LAT-1 and are visible after it.
  - With SUM_LAT=1 the output register is loaded at edge k.
  - cout and p/g follow the same rule with COUT_LAT and PG_LAT.
- Throughput: one new sample per cycle. Back-to-back samples emerge in order with no gaps or merging.
- When in_valid is low:
  - The stage loads valid=0.
  - Data bits load 0, so idle outputs read 0 rather than holding stale values.
- Independence of paths:
  - The three pipelines are independent.
  - With unequal latencies, sum and cout of the same sample appear on different cycles.
  - The consumer aligns them using the valid flags.
- Arithmetic identity: sum + 2*cout equals a+b+cin for each sample, once both outputs are valid.
- Parameter check: an out-of-range parameter (0 or >16) stops elaboration with a fatal error.
- Structure: no internal state beyond the pipeline registers; no X propagation after reset.

Test Plan:
- Reset mid-flight:
  - Defaults; drive a=1, b=1, cin=1, in_valid=1 for 1 cycle.
  - Assert rst asynchronously before the 2nd edge.
  - Required: all outputs 0 at once and stay 0. The sample never appears, even after rst releases.
- Exhaustive truth table:
  - Defaults; stream all 8 combinations of {a,b,cin} back-to-back with in_valid=1.
  - Required: sum/cout sequence 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1, appearing 2 cycles after each sample with no gaps.
  - Required: p/g appear after 1 cycle.
- Latency check:
  - Defaults; single sample a=1, b=0, cin=1.
  - Required: pg_valid=1 with p=1, g=0 exactly 1 cycle after sampling; sum_valid=1 with sum=0 and cout_valid=1 with cout=1 exactly 2 cycles after.
  - Required: all valids low on the following cycle.
- Skewed latencies:
  - SUM_LAT=3, COUT_LAT=1; sample a=1, b=1, cin=0.
  - Required: cout=1 with cout_valid after 1 cycle; sum=0 with sum_valid after 3 cycles; identity holds.
- Bubbles:
  - Alternate in_valid 1/0 with a=1, b=0, cin=0.
  - Required: sum_valid toggles 1/0 with the same 2-cycle offset; sum=1 on valid cycles, 0 otherwise.
- Ripple chain:
  - Four instances chained cin<-cout with aligned valids; add 4'b1111 + 4'b0001, cin=0.
  - Required: final sum 4'b0000 and carry 1, with the 4th cout valid after 4*COUT_LAT cycles.

Source files
------------

// File: rtl/full_adder_delay_reg.sv
// 1-bit full adder whose sum, carry-out and propagate/generate results each travel
// through an independent shift-register pipeline, modelling gate delay as latency.
module full_adder_delay_reg #(
  parameter int SUM_LAT  = 2,
  parameter int COUT_LAT = 2,
  parameter int PG_LAT   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic sum_valid,
  output logic cout,
  output logic cout_valid,
  output logic p,
  output logic g,
  output logic pg_valid
);

  generate
    if (SUM_LAT < 1 || SUM_LAT > 16) begin : g_bad_sum_lat
      $fatal(1, "full_adder_delay_reg: SUM_LAT must be within 1..16");
    end
    if (COUT_LAT < 1 || COUT_LAT > 16) begin : g_bad_cout_lat
      $fatal(1, "full_adder_delay_reg: COUT_LAT must be within 1..16");
    end
    if (PG_LAT < 1 || PG_LAT > 16) begin : g_bad_pg_lat
      $fatal(1, "full_adder_delay_reg: PG_LAT must be within 1..16");
    end
  endgenerate

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Data is gated by in_valid so idle slots carry 0 rather than stale results.
  logic w_sum;
  logic w_cout;
  logic w_p;
  logic w_g;

  assign w_sum  = in_valid & fa_sum(a, b, cin);
  assign w_cout = in_valid & fa_carry(a, b, cin);
  assign w_p    = in_valid & (a ^ b);
  assign w_g    = in_valid & (a & b);

  logic [SUM_LAT-1:0]  r_sum_d;
  logic [SUM_LAT-1:0]  r_sum_v;
  logic [COUT_LAT-1:0] r_cout_d;
  logic [COUT_LAT-1:0] r_cout_v;
  logic [PG_LAT-1:0]   r_p_d;
  logic [PG_LAT-1:0]   r_g_d;
  logic [PG_LAT-1:0]   r_pg_v;

  // Sum path: SUM_LAT stages, shifting every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_d <= '0;
      r_sum_v <= '0;
    end else begin
      r_sum_d[0] <= w_sum;
      r_sum_v[0] <= in_valid;
      for (int i = 1; i < SUM_LAT; i++) begin
        r_sum_d[i] <= r_sum_d[i-1];
        r_sum_v[i] <= r_sum_v[i-1];
      end
    end
  end

  // Carry path: COUT_LAT stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cout_d <= '0;
      r_cout_v <= '0;
    end else begin
      r_cout_d[0] <= w_cout;
      r_cout_v[0] <= in_valid;
      for (int i = 1; i < COUT_LAT; i++) begin
        r_cout_d[i] <= r_cout_d[i-1];
        r_cout_v[i] <= r_cout_v[i-1];
      end
    end
  end

  // Propagate/generate path: PG_LAT stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_d  <= '0;
      r_g_d  <= '0;
      r_pg_v <= '0;
    end else begin
      r_p_d[0]  <= w_p;
      r_g_d[0]  <= w_g;
      r_pg_v[0] <= in_valid;
      for (int i = 1; i < PG_LAT; i++) begin
        r_p_d[i]  <= r_p_d[i-1];
        r_g_d[i]  <= r_g_d[i-1];
        r_pg_v[i] <= r_pg_v[i-1];
      end
    end
  end

  assign sum        = r_sum_d[SUM_LAT-1];
  assign sum_valid  = r_sum_v[SUM_LAT-1];
  assign cout       = r_cout_d[COUT_LAT-1];
  assign cout_valid = r_cout_v[COUT_LAT-1];
  assign p          = r_p_d[PG_LAT-1];
  assign g          = r_g_d[PG_LAT-1];
  assign pg_valid   = r_pg_v[PG_LAT-1];

endmodule

// File: tb/tb_full_adder_delay_reg.sv
// Bench for full_adder_delay_reg: default and skewed-latency cells share random stimulus
// checked against a sample-history model; a 4-cell ripple chain is checked directly.
module tb_full_adder_delay_reg;

  localparam int RC_CL = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic cin = 1'b0;

  logic s0, sv0, c0, cv0, p0, g0, pgv0;
  logic s1, sv1, c1, cv1, p1, g1, pgv1;

  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  full_adder_delay_reg u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(s0), .sum_valid(sv0), .cout(c0), .cout_valid(cv0),
    .p(p0), .g(g0), .pg_valid(pgv0)
  );

  full_adder_delay_reg #(.SUM_LAT(3), .COUT_LAT(1), .PG_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(s1), .sum_valid(sv1), .cout(c1), .cout_valid(cv1),
    .p(p1), .g(g1), .pg_valid(pgv1)
  );

  // Ripple chain: cell i takes its carry and valid from cell i-1; its a/b bits are
  // delayed by i*RC_CL cycles so they line up with the incoming carry.
  logic       rc_v_in = 1'b0;
  logic [3:0] rc_a_in = '0;
  logic [3:0] rc_b_in = '0;
  logic [3:0] ha_hist [1:8];
  logic [3:0] hb_hist [1:8];
  logic [3:0] rc_a, rc_b, rc_cin, rc_vin;
  logic [3:0] rc_sum, rc_sv, rc_cout, rc_cv, rc_p, rc_g, rc_pgv;

  always @(posedge clk) begin
    ha_hist[1] <= rc_a_in;
    hb_hist[1] <= rc_b_in;
    for (int j = 2; j <= 8; j++) begin
      ha_hist[j] <= ha_hist[j-1];
      hb_hist[j] <= hb_hist[j-1];
    end
  end

  always_comb begin
    rc_a   = '0;
    rc_b   = '0;
    rc_cin = '0;
    rc_vin = '0;
    rc_a[0]   = rc_a_in[0];
    rc_b[0]   = rc_b_in[0];
    rc_vin[0] = rc_v_in;
    for (int i = 1; i < 4; i++) begin
      rc_a[i]   = ha_hist[i*RC_CL][i];
      rc_b[i]   = hb_hist[i*RC_CL][i];
      rc_cin[i] = rc_cout[i-1];
      rc_vin[i] = rc_cv[i-1];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rc
    full_adder_delay_reg #(.SUM_LAT(2), .COUT_LAT(RC_CL), .PG_LAT(1)) u_cell (
      .clk(clk), .rst(rst), .in_valid(rc_vin[gi]), .a(rc_a[gi]), .b(rc_b[gi]),
      .cin(rc_cin[gi]), .sum(rc_sum[gi]), .sum_valid(rc_sv[gi]), .cout(rc_cout[gi]),
      .cout_valid(rc_cv[gi]), .p(rc_p[gi]), .g(rc_g[gi]), .pg_valid(rc_pgv[gi])
    );
  end

  // Model: hist[n] is {valid,a,b,cin} accepted at the n-th clock edge since time 0;
  // any reset wipes every recorded sample so none can emerge later.
  bit [3:0] hist [4096];
  int e = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 4096; j++) hist[j] <= '0;
    end else if (e < 4094) begin
      hist[e+1] <= {in_valid, a, b, cin};
      e <= e + 1;
    end
  end

  // Expected {valid, sum, cout, p, g} for a path of the given latency.
  function automatic logic [4:0] expect_at(input int lat);
    bit [3:0] h;
    int idx;
    int n;
    int ab;
    idx = e - lat + 1;
    h = (idx >= 1) ? hist[idx] : 4'b0;
    if (!h[3]) return 5'b0;
    n  = int'(h[2]) + int'(h[1]) + int'(h[0]);
    ab = int'(h[2]) + int'(h[1]);
    return {1'b1, n % 2 == 1, n >= 2, ab == 1, ab == 2};
  endfunction

  task automatic check(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] xs, xc, xp;
    xs = expect_at(2); xc = expect_at(2); xp = expect_at(1);
    check("m0_sum_valid", sv0, xs[4]);
    check("m0_sum", s0, xs[3]);
    check("m0_cout_valid", cv0, xc[4]);
    check("m0_cout", c0, xc[2]);
    check("m0_pg_valid", pgv0, xp[4]);
    check("m0_p", p0, xp[1]);
    check("m0_g", g0, xp[0]);
    xs = expect_at(3); xc = expect_at(1); xp = expect_at(2);
    check("m1_sum_valid", sv1, xs[4]);
    check("m1_sum", s1, xs[3]);
    check("m1_cout_valid", cv1, xc[4]);
    check("m1_cout", c1, xc[2]);
    check("m1_pg_valid", pgv1, xp[4]);
    check("m1_p", p1, xp[1]);
    check("m1_g", g1, xp[0]);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic ai, input logic bi, input logic ci);
    in_valid = v; a = ai; b = bi; cin = ci;
  endtask

  initial begin
    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    logic [3:0] cap;
    logic [3:0] got;
    logic       c_cap;
    int         exp_add;
    tt_sum  = 8'b1001_0110;
    tt_cout = 8'b1110_1000;
    rst = 1'b1;
    step();
    step();
    check("reset_sum_valid", sv0, 1'b0);
    check("reset_cout_valid", cv0, 1'b0);
    check("reset_pg_valid", pgv0, 1'b0);
    rst = 1'b0;
    step();

    // Reset while a sample is in flight.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("midflight_pg_before_rst", pgv0, 1'b1);
    rst = 1'b1;
    #1;
    check("midflight_sum", s0, 1'b0);
    check("midflight_sum_valid", sv0, 1'b0);
    check("midflight_cout", c0, 1'b0);
    check("midflight_cout_valid", cv0, 1'b0);
    check("midflight_p", p0, 1'b0);
    check("midflight_g", g0, 1'b0);
    check("midflight_pg_valid", pgv0, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("midflight_no_sum_valid", sv0, 1'b0);
      check("midflight_no_cout_valid", cv0, 1'b0);
      check("midflight_no_pg_valid", pgv0, 1'b0);
    end

    // Exhaustive truth table, back-to-back; combo index = {a,b,cin}.
    for (int j = 0; j < 10; j++) begin
      if (j >= 2) begin
        check("tt_sum_valid", sv0, 1'b1);
        check("tt_sum", s0, tt_sum[j-2]);
        check("tt_cout_valid", cv0, 1'b1);
        check("tt_cout", c0, tt_cout[j-2]);
      end
      if (j >= 1 && j <= 8) begin
        check("tt_pg_valid", pgv0, 1'b1);
        check("tt_p", p0, (((j-1) >> 2) & 1) != (((j-1) >> 1) & 1));
        check("tt_g", g0, (((j-1) >> 2) & 1) == 1 && (((j-1) >> 1) & 1) == 1);
      end
      if (j < 8) drive(1'b1, j[2], j[1], j[0]);
      else drive(1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int j = 0; j < 3; j++) step();

    // Single-sample latency on the default cell.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_pg_valid_1", pgv0, 1'b1);
    check("lat_p_1", p0, 1'b1);
    check("lat_g_1", g0, 1'b0);
    check("lat_sum_valid_1", sv0, 1'b0);
    check("lat_cout_valid_1", cv0, 1'b0);
    step();
    check("lat_sum_valid_2", sv0, 1'b1);
    check("lat_sum_2", s0, 1'b0);
    check("lat_cout_valid_2", cv0, 1'b1);
    check("lat_cout_2", c0, 1'b1);
    check("lat_pg_valid_2", pgv0, 1'b0);
    step();
    check("lat_sum_valid_3", sv0, 1'b0);
    check("lat_cout_valid_3", cv0, 1'b0);
    check("lat_pg_valid_3", pgv0, 1'b0);
    step();

    // Skewed latencies (SUM_LAT=3, COUT_LAT=1).
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("skew_cout_valid_1", cv1, 1'b1);
    check("skew_cout_1", c1, 1'b1);
    check("skew_sum_valid_1", sv1, 1'b0);
    c_cap = c1;
    step();
    check("skew_sum_valid_2", sv1, 1'b0);
    check("skew_cout_valid_2", cv1, 1'b0);
    step();
    check("skew_sum_valid_3", sv1, 1'b1);
    check("skew_sum_3", s1, 1'b0);
    check_int("skew_identity", int'(s1) + 2 * int'(c_cap), 2);
    step();

    // Bubbles: in_valid alternates 1/0 with a=1.
    for (int j = 0; j < 10; j++) begin
      if (j >= 2) begin
        check("bubble_sum_valid", sv0, (j - 2) < 8 && (j - 2) % 2 == 0);
        check("bubble_sum", s0, (j - 2) < 8 && (j - 2) % 2 == 0);
      end
      drive(j < 8 && j % 2 == 0, 1'b1, 1'b0, 1'b0);
      step();
    end

    // Ripple chain: 4'b1111 + 4'b0001.
    cap = '0;
    got = '0;
    rc_v_in = 1'b1; rc_a_in = 4'b1111; rc_b_in = 4'b0001;
    exp_add = 15 + 1;
    for (int n = 1; n <= 4 * RC_CL + 3; n++) begin
      step();
      rc_v_in = 1'b0; rc_a_in = '0; rc_b_in = '0;
      for (int i = 0; i < 4; i++) begin
        if (rc_sv[i]) begin
          cap[i] = rc_sum[i];
          got[i] = 1'b1;
        end
      end
      if (n == 4 * RC_CL - 1) check("rc_cout3_valid_early", rc_cv[3], 1'b0);
      if (n == 4 * RC_CL) begin
        check("rc_cout3_valid", rc_cv[3], 1'b1);
        check("rc_cout3", rc_cout[3], exp_add >= 16);
      end
    end
    check_int("rc_sum_bits_seen", int'(got), 15);
    check_int("rc_sum", int'(cap), exp_add % 16);

    // Randomized traffic with occasional asynchronous resets.
    for (int j = 0; j < 400; j++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 49) == 0) rst = 1'b1;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
